alu_mul_sequencer: RTL and testbench

//  Multi-cycle unsigned shift-and-add multiplier controller. It drives the shared 32-bit ArithmeticLogicUnit
//  (A/B/FunSel/WF) and reads ALUOut back. Multiplication runs over several cycles with no dedicated multiplier.
//  It sits beside the ALU in the datapath; the control unit launches it with Start and waits for Done.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select encodings, flag bit positions and
// the state type of the shift-and-add multiply sequencer.
package alu_pkg;

  localparam logic [4:0] FS_PASSA = 5'b10000;
  localparam logic [4:0] FS_ADD32 = 5'b10100;
  localparam logic [4:0] FS_LSL32 = 5'b11011;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD,
    ST_SHIFT,
    ST_FLAGS,
    ST_DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier controller that borrows the shared ALU
// for every add and shift; Product keeps the low WIDTH bits, Ovf the rest.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ITER       = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Mcand,
  input  logic [WIDTH-1:0] Mplr,
  input  logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [4:0]       ALU_FunSel,
  output logic             ALU_WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic             Ovf
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER);

  mul_state_t state, state_next;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] mp_shr;

  assign cnt_inc = cnt + CNT_ONE;
  assign mp_shr  = mp >> 1;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      cnt     <= '0;
      Product <= '0;
      Ovf     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            mc  <= Mcand;
            mp  <= Mplr;
            acc <= '0;
            cnt <= '0;
            Ovf <= 1'b0;
          end
        end
        ST_ADD: begin
          acc <= ALUOut;
          if (ALUOut < acc) Ovf <= 1'b1;
        end
        ST_SHIFT: begin
          // A set top bit of mc is lost by the shift; it only matters if a later multiplier bit still needs it.
          mc  <= ALUOut;
          if (mc[WIDTH-1] && (mp[WIDTH-1:1] != '0)) Ovf <= 1'b1;
          mp  <= mp_shr;
          cnt <= cnt_inc;
        end
        ST_FLAGS: Product <= acc;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ALU_A      = '0;
    ALU_B      = '0;
    ALU_FunSel = FS_PASSA;
    ALU_WF     = 1'b0;
    Busy       = (state != ST_IDLE);
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (EARLY_EXIT && (mp == '0)) state_next = ST_FLAGS;
        else if (mp[0])               state_next = ST_ADD;
        else                          state_next = ST_SHIFT;
      end
      ST_ADD: begin
        ALU_A      = acc;
        ALU_B      = mc;
        ALU_FunSel = FS_ADD32;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        ALU_A      = mc;
        ALU_FunSel = FS_LSL32;
        if ((cnt_inc == CNT_LAST) || (EARLY_EXIT && (mp_shr == '0))) state_next = ST_FLAGS;
        else if (mp[1])                                              state_next = ST_ADD;
        else                                                         state_next = ST_SHIFT;
      end
      ST_FLAGS: begin
        // Pass the product through with flag write so Z/N describe the result.
        ALU_A      = acc;
        ALU_WF     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        Done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural model of the
// shared ALU closing the loop on ALUOut.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int MAX_CYC = 100;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [31:0] Mcand;
  logic [31:0] Mplr;
  logic [31:0] ALUOut;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic        Busy;
  logic        Done;
  logic [31:0] Product;
  logic        Ovf;

  int assert_count = 0;
  int fail_count   = 0;

  logic [4:0] trace_fs [0:MAX_CYC];
  logic       trace_wf [0:MAX_CYC];

  alu_mul_sequencer #(.WIDTH(32), .ITER(32), .EARLY_EXIT(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mcand(Mcand), .Mplr(Mplr),
    .ALUOut(ALUOut), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .Busy(Busy), .Done(Done), .Product(Product), .Ovf(Ovf)
  );

  always_comb begin
    case (ALU_FunSel)
      FS_PASSA: ALUOut = ALU_A;
      FS_ADD32: ALUOut = ALU_A + ALU_B;
      FS_LSL32: ALUOut = ALU_A << 1;
      default:  ALUOut = 32'hDEAD_BEEF;
    endcase
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Launch one multiply and follow it to Done; cycles=1 is the LOAD cycle, 0 means timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int cycles);
    @(negedge Clock);
    Mcand = a;
    Mplr  = b;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    cycles = 0;
    for (int k = 1; k <= MAX_CYC; k++) begin
      trace_fs[k] = ALU_FunSel;
      trace_wf[k] = ALU_WF;
      if (Done) begin
        cycles = k;
        break;
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b0;
    Mcand = '0;
    Mplr  = '0;
    repeat (2) @(negedge Clock);
    assert_count++;
    if (Busy !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_busy: got %b want 0", Busy); end
    assert_count++;
    if (Done !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_done: got %b want 0", Done); end
    assert_count++;
    if (Product !== 32'h0) begin fail_count++; $display("[TB] FAIL reset_product: got %h want 0", Product); end
    assert_count++;
    if (Ovf !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_ovf: got %b want 0", Ovf); end
    assert_count++;
    if ({ALU_A, ALU_B, ALU_FunSel, ALU_WF} !== {32'h0, 32'h0, FS_PASSA, 1'b0}) begin
      fail_count++;
      $display("[TB] FAIL reset_idle_drive: got A=%h B=%h fs=%b wf=%b want 0/0/10000/0", ALU_A, ALU_B, ALU_FunSel, ALU_WF);
    end
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_basic();
    int cyc;
    logic [4:0] exp_fs [1:8];
    logic       exp_wf [1:8];
    exp_fs = '{FS_PASSA, FS_ADD32, FS_LSL32, FS_LSL32, FS_ADD32, FS_LSL32, FS_PASSA, FS_PASSA};
    exp_wf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_op(32'd3, 32'd5, cyc);
    assert_count++;
    if (cyc != 8) begin fail_count++; $display("[TB] FAIL basic_latency: got %0d want 8", cyc); end
    assert_count++;
    if (Product !== 32'd15) begin fail_count++; $display("[TB] FAIL basic_product: got %0d want 15", Product); end
    assert_count++;
    if (Ovf !== 1'b0) begin fail_count++; $display("[TB] FAIL basic_ovf: got %b want 0", Ovf); end
    if (cyc == 8) begin
      for (int k = 1; k <= 8; k++) begin
        assert_count++;
        if ({trace_fs[k], trace_wf[k]} !== {exp_fs[k], exp_wf[k]}) begin
          fail_count++;
          $display("[TB] FAIL basic_seq_%0d: got fs=%b wf=%b want fs=%b wf=%b", k, trace_fs[k], trace_wf[k], exp_fs[k], exp_wf[k]);
        end
      end
    end
    @(negedge Clock);
    assert_count++;
    if ({Busy, Done} !== 2'b00) begin fail_count++; $display("[TB] FAIL basic_after_done: got busy/done=%b want 00", {Busy, Done}); end
  endtask

  task automatic test_zero_mplr();
    int cyc;
    int wf_seen;
    run_op(32'd9, 32'd0, cyc);
    assert_count++;
    if (cyc != 3) begin fail_count++; $display("[TB] FAIL zero_latency: got %0d want 3", cyc); end
    assert_count++;
    if (Product !== 32'd0) begin fail_count++; $display("[TB] FAIL zero_product: got %0d want 0", Product); end
    wf_seen = 0;
    for (int k = 1; k <= cyc; k++) if (trace_wf[k] === 1'b1) wf_seen++;
    assert_count++;
    if (wf_seen != 1) begin fail_count++; $display("[TB] FAIL zero_wf_count: got %0d want 1", wf_seen); end
  endtask

  task automatic test_worst_case();
    int cyc;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    assert_count++;
    if (cyc != 67) begin fail_count++; $display("[TB] FAIL worst_latency: got %0d want 67", cyc); end
    assert_count++;
    if (Product !== 32'h0000_0001) begin fail_count++; $display("[TB] FAIL worst_product: got %h want 00000001", Product); end
    assert_count++;
    if (Ovf !== 1'b1) begin fail_count++; $display("[TB] FAIL worst_ovf: got %b want 1", Ovf); end
    // Zero multiplicand right after an overflow: Ovf must clear, all bits still examined.
    run_op(32'h0, 32'hFFFF_FFFF, cyc);
    assert_count++;
    if (cyc != 67) begin fail_count++; $display("[TB] FAIL zero_mcand_latency: got %0d want 67", cyc); end
    assert_count++;
    if ({Product, Ovf} !== {32'h0, 1'b0}) begin fail_count++; $display("[TB] FAIL zero_mcand_result: got %h ovf=%b want 0 ovf=0", Product, Ovf); end
  endtask

  task automatic test_shift_ovf();
    int cyc;
    run_op(32'h0001_0000, 32'h0001_0000, cyc);
    assert_count++;
    if (cyc != 21) begin fail_count++; $display("[TB] FAIL shiftovf_latency: got %0d want 21", cyc); end
    assert_count++;
    if ({Product, Ovf} !== {32'h0, 1'b1}) begin fail_count++; $display("[TB] FAIL shiftovf_result: got %h ovf=%b want 0 ovf=1", Product, Ovf); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge Clock);
    Mcand = 32'd7;
    Mplr  = 32'd7;
    Start = 1'b1;
    @(negedge Clock);
    Mcand = 32'd2;
    Mplr  = 32'd3;
    cyc = 0;
    for (int k = 1; k <= MAX_CYC; k++) begin
      if (Done) begin cyc = k; break; end
      @(negedge Clock);
    end
    assert_count++;
    if (cyc != 9) begin fail_count++; $display("[TB] FAIL busy_start_latency: got %0d want 9", cyc); end
    assert_count++;
    if (Product !== 32'd49) begin fail_count++; $display("[TB] FAIL busy_start_product: got %0d want 49", Product); end
    @(negedge Clock);
    assert_count++;
    if (Busy !== 1'b0) begin fail_count++; $display("[TB] FAIL done_start_idle: got busy=%b want 0", Busy); end
    @(negedge Clock);
    Start = 1'b0;
    assert_count++;
    if (Busy !== 1'b1) begin fail_count++; $display("[TB] FAIL held_start_launch: got busy=%b want 1", Busy); end
    cyc = 0;
    for (int k = 1; k <= MAX_CYC; k++) begin
      if (Done) begin cyc = k; break; end
      @(negedge Clock);
    end
    assert_count++;
    if (cyc != 7) begin fail_count++; $display("[TB] FAIL second_op_latency: got %0d want 7", cyc); end
    assert_count++;
    if (Product !== 32'd6) begin fail_count++; $display("[TB] FAIL second_op_product: got %0d want 6", Product); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int shifts;
    bit hit;
    @(negedge Clock);
    Mcand = 32'd5;
    Mplr  = 32'd8;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    shifts = 0;
    hit = 1'b0;
    for (int k = 1; k <= MAX_CYC; k++) begin
      if (ALU_FunSel === FS_LSL32) shifts++;
      if (shifts == 3) begin hit = 1'b1; break; end
      @(negedge Clock);
    end
    assert_count++;
    if (!hit) begin fail_count++; $display("[TB] FAIL midreset_third_shift: got %0d shifts want 3", shifts); end
    Reset = 1'b0;
    @(negedge Clock);
    assert_count++;
    if ({Busy, Done, Ovf, ALU_WF} !== 4'b0000) begin
      fail_count++;
      $display("[TB] FAIL midreset_ctrl: got busy/done/ovf/wf=%b want 0000", {Busy, Done, Ovf, ALU_WF});
    end
    assert_count++;
    if (Product !== 32'h0) begin fail_count++; $display("[TB] FAIL midreset_product: got %0d want 0", Product); end
    Reset = 1'b1;
    run_op(32'd6, 32'd7, cyc);
    assert_count++;
    if ({cyc == 9, Product} !== {1'b1, 32'd42}) begin
      fail_count++;
      $display("[TB] FAIL after_reset_op: got cycles=%0d product=%0d want 9/42", cyc, Product);
    end
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    Mcand = '0;
    Mplr  = '0;
    test_reset();
    test_basic();
    test_zero_mplr();
    test_worst_case();
    test_shift_ovf();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
